conv_stream_host: RTL and testbench

- Streaming host-side endpoint for the convolution accelerator.
- Transmits a host-loaded LENX-sample x vector into the accelerator's x input channel (valid/ready transmitter side).
- Receives the SIZE y results from the accelerator's output channel (valid/ready receiver side) into a readable result buffer.
- Sits between a host/test controller and the accelerator top; allows one run per start pulse.

---
 rtl/conv_stream_host.sv | 77 +++++++
 tb/tb_conv_stream_host.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_host.sv
// conv_stream_host: host-side stream endpoint for the convolution accelerator.
// Sends a loaded x vector over valid/ready and captures the y results into a readable buffer.
module conv_stream_host #(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int SIZE  = LENX - LENF + 1,
    parameter int ADDRX = 3,
    parameter int ADDRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_x,
    input  logic [ADDRX-1:0] wr_addr_x,
    input  logic [WIDTH-1:0] wr_data_x,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    input  logic [ADDRY-1:0] rd_addr_y,
    output logic [WIDTH-1:0] rd_data_y,
    output logic [ADDRY:0]   rx_count
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [ADDRX:0] NX = (ADDRX+1)'(LENX);
    localparam logic [ADDRY:0] NY = (ADDRY+1)'(SIZE);
    logic [1:0] state;
    logic [WIDTH-1:0] xbuf [LENX];
    logic [WIDTH-1:0] ybuf [SIZE];
    logic [ADDRX:0] tx_cnt, tx_nxt;
    logic [ADDRY:0] rx_cnt, rx_nxt;
    logic tx_hs, rx_hs, go;
    assign tx_hs = m_valid_x & m_ready_x;
    assign rx_hs = s_valid_y & s_ready_y;
    assign go = start & (state != RUN);
    assign tx_nxt = tx_cnt + (ADDRX+1)'(tx_hs);
    assign rx_nxt = rx_cnt + (ADDRY+1)'(rx_hs);
    assign busy = state == RUN;
    assign done = state == DONE;
    assign rx_count = rx_cnt;
    // x writes are locked out during a run, so the head sample stays stable under stalls
    assign m_data_out_x = m_valid_x ? xbuf[tx_cnt[ADDRX-1:0]] : '0;
    always_ff @(posedge clk) begin
        if (wr_en_x && state != RUN && {1'b0, wr_addr_x} < NX) xbuf[wr_addr_x] <= wr_data_x;
        if (rx_hs) ybuf[rx_cnt[ADDRY-1:0]] <= s_data_in_y;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            m_valid_x <= 1'b0;
            s_ready_y <= 1'b0;
            rd_data_y <= '0;
        end else begin
            rd_data_y <= ({1'b0, rd_addr_y} < NY) ? ybuf[rd_addr_y] : '0;
            if (go) begin
                state     <= RUN;
                tx_cnt    <= '0;
                rx_cnt    <= '0;
                m_valid_x <= 1'b1;
                s_ready_y <= 1'b1;
            end else if (state == RUN) begin
                tx_cnt    <= tx_nxt;
                rx_cnt    <= rx_nxt;
                m_valid_x <= tx_nxt != NX;
                s_ready_y <= rx_nxt != NY;
                if (tx_nxt == NX && rx_nxt == NY) state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_host.sv
// tb_conv_stream_host: scoreboard bench for conv_stream_host.
module tb_conv_stream_host;
    logic clk = 0, reset = 0, wr_en_x = 0, start = 0, m_ready_x = 0, s_valid_y = 0;
    logic [2:0] wr_addr_x = 0, rd_addr_y = 0;
    logic [15:0] wr_data_x = 0, s_data_in_y = 0;
    logic busy, done, m_valid_x, s_ready_y;
    logic [15:0] m_data_out_x, rd_data_y;
    logic [3:0] rx_count;
    int n_cmp = 0, n_bad = 0, tx_beats = 0, rmode = 0, rpat_i = 0;
    bit rpat [6] = '{1, 0, 0, 1, 0, 1};
    logic [15:0] exp_x [$];
    logic [15:0] exp_y [$];
    logic stall_prev = 0;
    logic [15:0] stall_data = 0;

    conv_stream_host dut (
        .clk(clk), .reset(reset), .wr_en_x(wr_en_x), .wr_addr_x(wr_addr_x), .wr_data_x(wr_data_x),
        .start(start), .busy(busy), .done(done), .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x),
        .m_ready_x(m_ready_x), .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr_y(rd_addr_y), .rd_data_y(rd_data_y), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready_x = rmode == 2 ? rpat[rpat_i % 6] : rmode == 1;
        rpat_i++;
    end

    // x monitor: inputs are settled by the falling edge, so a valid&ready seen here lands on the next rise
    always @(negedge clk) begin
        if (!reset) stall_prev = 0;
        else begin
            if (stall_prev) begin
                check("tx_hold_valid", m_valid_x, 1);
                check("tx_hold_data", m_data_out_x, stall_data);
            end
            stall_prev = m_valid_x && !m_ready_x;
            stall_data = m_data_out_x;
            if (m_valid_x && m_ready_x) begin
                tx_beats++;
                if (exp_x.size() == 0) check("tx_extra", tx_beats, 0);
                else check("tx_data", m_data_out_x, exp_x.pop_front());
            end
        end
    end

    task automatic go();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic load_x();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 wr_en_x = 1; wr_addr_x = 3'(i); wr_data_x = 16'(i + 1);
        end
        @(posedge clk); #1 wr_en_x = 0;
    endtask

    task automatic push_x();
        exp_x.delete();
        for (int i = 1; i <= 8; i++) exp_x.push_back(16'(i));
        tx_beats = 0;
    endtask

    task automatic wait_tx(input int n, input int lim, output int k);
        for (k = 1; k <= lim; k++) begin
            @(posedge clk);
            if (tx_beats >= n) break;
        end
        check("tx_wait", k <= lim, 1);
        #1;
    endtask

    task automatic send_y(input logic [15:0] v, input int gap);
        int k;
        repeat (gap) @(posedge clk);
        #1 s_valid_y = 1; s_data_in_y = v;
        exp_y.push_back(v);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready_y) break;
        end
        check("y_wait", k < 50, 1);
        @(posedge clk); #1 s_valid_y = 0;
    endtask

    task automatic readback();
        for (int a = 0; a < 5; a++) begin
            rd_addr_y = 3'(a);
            @(posedge clk); #1;
            check("rd_y", rd_data_y, exp_y.size() ? exp_y.pop_front() : 16'hxxxx);
        end
        rd_addr_y = 3'd7;
        @(posedge clk); #1 check("rd_oob", rd_data_y, 0);
    endtask

    task automatic check_done();
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("rx_count", rx_count, 5);
        check("s_ready_end", s_ready_y, 0);
        check("m_valid_end", m_valid_x, 0);
        check("tx_beats", tx_beats, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [15:0] ys [5] = '{16'd11, 16'd22, 16'hfff0, 16'd44, 16'd55};
        int gaps [5] = '{0, 2, 1, 3, 0};
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mvalid", m_valid_x, 0);
        check("rst_sready", s_ready_y, 0);
        check("rst_rxcount", rx_count, 0);
        check("rst_rdata", rd_data_y, 0);
        check("rst_mdata", m_data_out_x, 0);
        #4 reset = 1;
        load_x();

        // run 1: free-flowing x, then back-to-back y
        push_x(); exp_y.delete(); rmode = 1;
        go();
        check("run1_busy", busy, 1);
        check("run1_valid", m_valid_x, 1);
        check("run1_sready", s_ready_y, 1);
        wait_tx(8, 50, k);
        check("tx_no_bubble", k, 8);
        check("tx_valid_drop", m_valid_x, 0);
        for (int i = 1; i <= 4; i++) send_y(16'(10 * i), 0);
        check("run1_not_done", done, 0);
        send_y(16'd50, 0);
        check_done();
        readback();

        // run 2: x backpressure, y with gaps, then a late beat that must be refused
        push_x(); exp_y.delete(); rmode = 2;
        go();
        wait_tx(8, 100, k);
        check("bp_valid_drop", m_valid_x, 0);
        for (int i = 0; i < 5; i++) send_y(ys[i], gaps[i]);
        check_done();
        #1 s_valid_y = 1; s_data_in_y = 16'd99;
        repeat (3) begin
            @(negedge clk); check("y_refused", s_ready_y, 0);
        end
        @(posedge clk); #1 s_valid_y = 0;
        check("rx_count_hold", rx_count, 5);
        readback();

        // run 3: x write and start during a run are ignored
        push_x(); exp_y.delete(); rmode = 2;
        go();
        repeat (2) @(posedge clk);
        #1 wr_en_x = 1; wr_addr_x = 0; wr_data_x = 16'd77; start = 1;
        @(posedge clk); #1 wr_en_x = 0; start = 0;
        check("run3_busy", busy, 1);
        wait_tx(8, 100, k);
        for (int i = 0; i < 5; i++) send_y(16'(60 + i), 0);
        check_done();
        check("run3_tx_left", exp_x.size(), 0);

        // run 4: restart from DONE, then async reset mid-run
        push_x(); rmode = 1;
        go();
        check("restart_rxcount", rx_count, 0);
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        wait_tx(3, 50, k);
        #1 reset = 0;
        #1;
        check("arst_mvalid", m_valid_x, 0);
        check("arst_sready", s_ready_y, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rxcount", rx_count, 0);
        @(posedge clk); #1 reset = 1;

        // run 5: after reset the x stream starts again at x[0]
        push_x(); exp_y.delete();
        go();
        wait_tx(8, 50, k);
        for (int i = 0; i < 5; i++) send_y(16'(100 + i), 0);
        check_done();
        readback();

        // run 6: last x beat and last y beat on the same edge
        push_x(); exp_y.delete(); rmode = 0;
        go();
        for (int i = 0; i < 4; i++) send_y(16'(200 + i), 0);
        @(negedge clk) rmode = 1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 s_valid_y = 1; s_data_in_y = 16'd204;
        exp_y.push_back(16'd204);
        check("same_pre_done", done, 0);
        check("same_pre_beats", tx_beats, 7);
        check("same_pre_sready", s_ready_y, 1);
        @(posedge clk); #1 s_valid_y = 0;
        check_done();
        readback();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
